// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Optional statistics are enabled by defining FIFO_ARB_STATS_EN.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    // Width of an owner index; a single requester still needs one bit.
    function automatic int owner_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: the first requester after 'last', wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int OW      = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [OW-1:0]      last,
    output logic               found,
    output logic [OW-1:0]      winner
);

    // Scan farthest-to-nearest so the nearest requester after 'last' wins.
    always_comb begin
        winner = last;
        found  = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            int idx;
            idx    = (int'(last) + k) % NUM_REQ;
            winner = req[idx] ? OW'(idx) : winner;
            found  = found | req[idx];
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async FIFO write port between NUM_REQ producers.
// Define FIFO_ARB_STATS_EN to add saturating beat_count/stall_count outputs.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 16
) (
    input  logic                         wr_clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*WIDTH-1:0]     req_data,
    output logic [NUM_REQ-1:0]           gnt,
    input  logic                         full,
    output logic                         wr_en,
    output logic [WIDTH-1:0]             write_data,
    output logic                         busy,
    output logic [owner_w(NUM_REQ)-1:0]  owner
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]             beat_count,
    output logic [CNT_W-1:0]             stall_count
`endif
);

    localparam int              OW        = owner_w(NUM_REQ);
    localparam logic [OW-1:0]   LAST_REQ  = OW'(NUM_REQ - 1);
    localparam logic [3:0]      BURST_MAX = 4'(MAX_BURST);

    arb_state_t      r_state;
    logic [3:0]      r_beat_cnt;
    logic [OW-1:0]   r_last;
    logic [OW-1:0]   r_owner;
    logic            r_busy;

    logic [OW-1:0]   w_winner;
    logic            w_found;
    logic [OW-1:0]   w_sel;
    logic            w_sel_valid;
    logic            w_grant;
    logic [3:0]      w_cnt_inc;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .OW      (OW)
    ) u_rr_pick (
        .req    (req),
        .last   (r_last),
        .found  (w_found),
        .winner (w_winner)
    );

    // In IDLE the picker's winner is offered; in BURST only the current owner.
    always_comb begin
        w_sel       = r_owner;
        w_sel_valid = 1'b0;
        if (r_state == ARB_IDLE) begin
            w_sel       = w_winner;
            w_sel_valid = w_found;
        end else begin
            w_sel       = r_owner;
            w_sel_valid = req[r_owner];
        end
    end

    assign w_grant   = reset & w_sel_valid & ~full;
    assign w_cnt_inc = r_beat_cnt + 4'd1;
    assign wr_en     = w_grant;
    assign busy      = r_busy;
    assign owner     = r_owner;

    // One-hot grant and owner data mux; data forced to zero when nothing is written.
    always_comb begin
        gnt        = {NUM_REQ{1'b0}};
        write_data = {WIDTH{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt[i]     = w_grant & (w_sel == OW'(i));
            write_data = write_data | ({WIDTH{gnt[i]}} & req_data[i*WIDTH +: WIDTH]);
        end
    end

    // Arbitration FSM: ownership, burst length and round-robin pointer.
    always_ff @(posedge wr_clk) begin
        if (!reset) begin
            r_state    <= ARB_IDLE;
            r_beat_cnt <= 4'd0;
            r_last     <= LAST_REQ;
            r_owner    <= LAST_REQ;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_found) begin
                        r_owner <= w_winner;
                        if (!full) begin
                            r_beat_cnt <= 4'd1;
                            if (BURST_MAX == 4'd1) begin
                                r_state <= ARB_IDLE;
                                r_last  <= w_winner;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state <= ARB_BURST;
                                r_busy  <= 1'b1;
                            end
                        end else begin
                            r_beat_cnt <= 4'd0;
                            r_state    <= ARB_BURST;
                            r_busy     <= 1'b1;
                        end
                    end else begin
                        r_state <= ARB_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ARB_BURST: begin
                    // A dropped request ends the burst even under back-pressure.
                    if (!req[r_owner]) begin
                        r_state <= ARB_IDLE;
                        r_last  <= r_owner;
                        r_busy  <= 1'b0;
                    end else if (!full) begin
                        r_beat_cnt <= w_cnt_inc;
                        if (w_cnt_inc == BURST_MAX) begin
                            r_state <= ARB_IDLE;
                            r_last  <= r_owner;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= ARB_BURST;
                            r_busy  <= 1'b1;
                        end
                    end else begin
                        r_state <= ARB_BURST;
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIFO_ARB_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_beat_count;
    logic [CNT_W-1:0] r_stall_count;

    // Saturating counters of written beats and stalled request cycles.
    always_ff @(posedge wr_clk) begin
        if (!reset) begin
            r_beat_count  <= {CNT_W{1'b0}};
            r_stall_count <= {CNT_W{1'b0}};
        end else begin
            if (w_grant && (r_beat_count != CNT_MAX)) begin
                r_beat_count <= r_beat_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if ((|req) && full && (r_stall_count != CNT_MAX)) begin
                r_stall_count <= r_stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign beat_count  = r_beat_count;
    assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed, table-driven bench for fifo_wr_arbiter with a queue model of the FIFO.
module tb_fifo_wr_arbiter;

    logic        wr_clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic        full;
    logic        wr_en;
    logic [7:0]  write_data;
    logic        busy;
    logic [1:0]  owner;
    logic [7:0]  d0;
`ifdef FIFO_ARB_STATS_EN
    logic [15:0] beat_count;
    logic [15:0] stall_count;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic       full;
        logic [7:0] d0;
        logic [3:0] gnt;
        logic [7:0] wd;
        logic       busy;
        logic [1:0] owner;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] fifo_q[$];

    assign req_data = {8'h40, 8'h30, 8'h20, d0};

    fifo_wr_arbiter #(
        .WIDTH     (8),
        .NUM_REQ   (4),
        .MAX_BURST (4),
        .CNT_W     (16)
    ) dut (
        .wr_clk     (wr_clk),
        .reset      (reset),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .full       (full),
        .wr_en      (wr_en),
        .write_data (write_data),
        .busy       (busy),
        .owner      (owner)
`ifdef FIFO_ARB_STATS_EN
        ,
        .beat_count  (beat_count),
        .stall_count (stall_count)
`endif
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic r, input logic [3:0] rq, input logic f,
                                input logic [7:0] d, input logic [3:0] g, input logic [7:0] w,
                                input logic b, input logic [1:0] o);
        vec_t v;
        v.rst_n = r; v.req = rq; v.full = f; v.d0 = d;
        v.gnt = g; v.wd = w; v.busy = b; v.owner = o;
        vecs.push_back(v);
    endfunction

    // Drive at negedge, check grant path mid-cycle, check registers after the edge.
    task automatic run_vec(input vec_t v, input int n);
        @(negedge wr_clk);
        reset = v.rst_n; req = v.req; full = v.full; d0 = v.d0;
        #2;
        chk($sformatf("v%0d_gnt", n), 32'(gnt), 32'(v.gnt));
        chk($sformatf("v%0d_wr_en", n), 32'(wr_en), 32'(v.gnt != 4'd0));
        chk($sformatf("v%0d_wdata", n), 32'(write_data), 32'(v.wd));
        @(posedge wr_clk);
        #1;
        chk($sformatf("v%0d_busy", n), 32'(busy), 32'(v.busy));
        chk($sformatf("v%0d_owner", n), 32'(owner), 32'(v.owner));
    endtask

    initial begin
        int cyc;
        int p;
        reset = 1'b0; req = 4'd0; full = 1'b0; d0 = 8'h10;

        // Reset state and grant gating during reset
        add(1'b0, 4'b0000, 1'b0, 8'h10, 4'b0000, 8'h00, 1'b0, 2'd3);
        add(1'b0, 4'b1111, 1'b0, 8'h10, 4'b0000, 8'h00, 1'b0, 2'd3);
        // Single producer, zero-latency grant
        add(1'b1, 4'b0001, 1'b0, 8'hA5, 4'b0001, 8'hA5, 1'b1, 2'd0);
        add(1'b1, 4'b0000, 1'b0, 8'h10, 4'b0000, 8'h00, 1'b0, 2'd0);
        add(1'b0, 4'b0000, 1'b0, 8'h10, 4'b0000, 8'h00, 1'b0, 2'd3);
        // All requesting: 4-beat bursts in round-robin order, no bubbles
        for (int k = 0; k < 16; k++) begin
            p = k / 4;
            add(1'b1, 4'b1111, 1'b0, 8'h10, 4'(1 << p), 8'((p + 1) * 16),
                1'(k % 4 != 3), 2'(p));
        end
        // p2 bursting, full mid-burst holds ownership, then completes 4 beats
        add(1'b1, 4'b0100, 1'b0, 8'h10, 4'b0100, 8'h30, 1'b1, 2'd2);
        add(1'b1, 4'b0100, 1'b0, 8'h10, 4'b0100, 8'h30, 1'b1, 2'd2);
        add(1'b1, 4'b0100, 1'b1, 8'h10, 4'b0000, 8'h00, 1'b1, 2'd2);
        add(1'b1, 4'b1111, 1'b1, 8'h10, 4'b0000, 8'h00, 1'b1, 2'd2);
        add(1'b1, 4'b1111, 1'b0, 8'h10, 4'b0100, 8'h30, 1'b1, 2'd2);
        add(1'b1, 4'b1111, 1'b0, 8'h10, 4'b0100, 8'h30, 1'b0, 2'd2);
        // p1 drops after 2 beats: bubble, then p2 wins over p0
        add(1'b1, 4'b0010, 1'b0, 8'h10, 4'b0010, 8'h20, 1'b1, 2'd1);
        add(1'b1, 4'b0010, 1'b0, 8'h10, 4'b0010, 8'h20, 1'b1, 2'd1);
        add(1'b1, 4'b0101, 1'b0, 8'h10, 4'b0000, 8'h00, 1'b0, 2'd1);
        add(1'b1, 4'b0101, 1'b0, 8'h10, 4'b0100, 8'h30, 1'b1, 2'd2);
        add(1'b1, 4'b0000, 1'b0, 8'h10, 4'b0000, 8'h00, 1'b0, 2'd2);
        // Reset mid-burst of p3, next grant to p0
        add(1'b1, 4'b1000, 1'b0, 8'h10, 4'b1000, 8'h40, 1'b1, 2'd3);
        add(1'b1, 4'b1000, 1'b0, 8'h10, 4'b1000, 8'h40, 1'b1, 2'd3);
        add(1'b0, 4'b1001, 1'b0, 8'h10, 4'b0000, 8'h00, 1'b0, 2'd3);
        add(1'b1, 4'b1001, 1'b0, 8'h10, 4'b0001, 8'h10, 1'b1, 2'd0);
        add(1'b1, 4'b0000, 1'b0, 8'h10, 4'b0000, 8'h00, 1'b0, 2'd0);
        // Winner chosen while full: owns without a beat, then writes
        add(1'b1, 4'b0100, 1'b1, 8'h10, 4'b0000, 8'h00, 1'b1, 2'd2);
        add(1'b1, 4'b0100, 1'b0, 8'h10, 4'b0100, 8'h30, 1'b1, 2'd2);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], i);
        end

        // FIFO model of depth 16: order and full after 16 beats, then stalls
        @(negedge wr_clk);
        reset = 1'b0; req = 4'd0; full = 1'b0; d0 = 8'h10;
        @(posedge wr_clk);
        fifo_q.delete();
        cyc = 0;
        while (fifo_q.size() < 16 && cyc < 40) begin
            @(negedge wr_clk);
            reset = 1'b1; req = 4'b1111; full = (fifo_q.size() >= 16);
            #2;
            if (wr_en) fifo_q.push_back(write_data);
            @(posedge wr_clk);
            cyc++;
        end
        chk("fifo_beats", 32'(fifo_q.size()), 32'd16);
        chk("fifo_cycles", 32'(cyc), 32'd16);
        for (int i = 0; i < fifo_q.size(); i++) begin
            chk($sformatf("fifo_order%0d", i), 32'(fifo_q[i]), 32'(((i / 4) + 1) * 16));
        end
        for (int s = 0; s < 5; s++) begin
            @(negedge wr_clk);
            full = (fifo_q.size() >= 16);
            #2;
            chk($sformatf("stall%0d_gnt", s), 32'(gnt), 32'd0);
            chk($sformatf("stall%0d_wr_en", s), 32'(wr_en), 32'd0);
            @(posedge wr_clk);
        end
        #1;
`ifdef FIFO_ARB_STATS_EN
        chk("beat_count", 32'(beat_count), 32'd16);
        chk("stall_count", 32'(stall_count), 32'd5);
`endif
        @(negedge wr_clk);
        req = 4'd0; full = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
